trap_filter_ctrl: RTL and testbench

Sequencing and configuration controller for the trapezoidal shaping filter (k/l/M pipeline). It holds the active k, l and M settings and accepts new settings over a valid/ready handshake. It flushes the filter's delay line on start or reconfiguration, waits for the pipeline to settle, then qualifies and registers filter output samples with a valid flag. It sits between the control/register interface and the filter datapath.

---
 rtl/trap_filter_ctrl_if.sv | 15 +
 rtl/trap_filter_ctrl.sv | 143 ++++++++++++++
 tb/tb_trap_filter_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_filter_ctrl_if.sv
// rtl/trap_filter_ctrl_if.sv - configuration handshake bundle for trap_filter_ctrl
interface trap_filter_ctrl_if #(
  parameter int KL_W = 6,
  parameter int M_W  = 8
) ();
  logic            cfg_valid;
  logic            cfg_ready;
  logic [KL_W-1:0] cfg_k;
  logic [KL_W-1:0] cfg_l;
  logic [M_W-1:0]  cfg_m;
  logic            cfg_err;

  modport master (output cfg_valid, cfg_k, cfg_l, cfg_m, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_k, cfg_l, cfg_m, output cfg_ready, cfg_err);
endinterface

// File: rtl/trap_filter_ctrl.sv
// rtl/trap_filter_ctrl.sv - trapezoidal filter sequencer/config controller
// Optional peak tracker: define TRAP_CTRL_PEAK_EN
module trap_filter_ctrl #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int KL_W             = 6,
  parameter int M_W              = 8,
  parameter int MAX_DEPTH        = 48,
  parameter int PIPE_LAT         = 4,
  parameter int K_DEF            = 8,
  parameter int L_DEF            = 12,
  parameter int M_DEF            = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  trap_filter_ctrl_if.slave                  cfg,
  input  logic                               start,
  input  logic                               stop,
  output logic                               flt_clear,
  output logic [KL_W-1:0]                    flt_k,
  output logic [KL_W-1:0]                    flt_l,
  output logic [M_W-1:0]                     flt_m,
  input  logic signed [SIZE_FILTER_DATA-1:0] flt_data,
  output logic signed [SIZE_FILTER_DATA-1:0] out_data,
  output logic                               out_valid,
`ifdef TRAP_CTRL_PEAK_EN
  output logic signed [SIZE_FILTER_DATA-1:0] peak_data,
  output logic                               peak_valid,
`endif
  output logic [1:0]                         state,
  output logic                               busy
);

  localparam int CNT_W = KL_W + 2;
  localparam logic [KL_W:0]  MAX_SUM = MAX_DEPTH[KL_W:0];
  localparam logic [CNT_W-1:0] LAT   = PIPE_LAT[CNT_W-1:0];

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, SETTLE = 2'd2, RUN = 2'd3} state_t;

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rdy_q, err_q;
  logic [KL_W:0]    cfg_sum;
  logic [CNT_W-1:0] act_kl, cfg_kl;
  logic             accept, cfg_ok, new_ok;

  assign cfg_sum = {1'b0, cfg.cfg_k} + {1'b0, cfg.cfg_l};
  assign cfg_ok  = (cfg.cfg_k != '0) && (cfg.cfg_l >= cfg.cfg_k) && (cfg_sum <= MAX_SUM);
  assign accept  = cfg.cfg_valid & rdy_q & ~stop;
  assign new_ok  = accept & cfg_ok;
  assign act_kl  = {2'b00, flt_k} + {2'b00, flt_l};
  assign cfg_kl  = {1'b0, cfg_sum};

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    if (stop) begin
      st_nxt  = IDLE;
      cnt_nxt = '0;
    end else begin
      case (st)
        IDLE: begin
          // any accepted config, valid or not, swallows a coincident start
          if (!accept && start) begin
            st_nxt  = FLUSH;
            cnt_nxt = act_kl + 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == 1) begin
            st_nxt  = SETTLE;
            cnt_nxt = act_kl + LAT;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == 1) begin
            st_nxt  = RUN;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        RUN: begin
          // flush length comes from the incoming config, registers update at the same edge
          if (new_ok) begin
            st_nxt  = FLUSH;
            cnt_nxt = cfg_kl + 1'b1;
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      cnt       <= '0;
      rdy_q     <= 1'b1;
      err_q     <= 1'b0;
      flt_k     <= K_DEF[KL_W-1:0];
      flt_l     <= L_DEF[KL_W-1:0];
      flt_m     <= M_DEF[M_W-1:0];
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      rdy_q     <= (st_nxt == IDLE) || (st_nxt == RUN);
      err_q     <= accept & ~cfg_ok;
      out_valid <= (st == RUN) && (st_nxt == RUN);
      if (new_ok) begin
        flt_k <= cfg.cfg_k;
        flt_l <= cfg.cfg_l;
        flt_m <= cfg.cfg_m;
      end
      if (st == RUN && !stop) out_data <= flt_data;
    end
  end

`ifdef TRAP_CTRL_PEAK_EN
  localparam logic signed [SIZE_FILTER_DATA-1:0] MOST_NEG = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_data  <= MOST_NEG;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= (st == RUN) && (st_nxt != RUN);
      if (st != RUN && st_nxt == RUN) peak_data <= MOST_NEG;
      else if (out_valid && out_data > peak_data) peak_data <= out_data;
    end
  end
`endif

  assign cfg.cfg_ready = rdy_q;
  assign cfg.cfg_err   = err_q;
  assign flt_clear     = (st == IDLE) || (st == FLUSH);
  assign busy          = (st == FLUSH) || (st == SETTLE);
  assign state         = st;

endmodule

// File: tb/tb_trap_filter_ctrl.sv
// tb/tb_trap_filter_ctrl.sv - self-checking bench for trap_filter_ctrl
module tb_trap_filter_ctrl;
  localparam int DW = 16;
  localparam int PIPE_LAT = 4;

  logic clk = 1'b0;
  logic reset, start, stop;
  logic flt_clear, out_valid, busy;
  logic [5:0] flt_k, flt_l;
  logic [7:0] flt_m;
  logic signed [DW-1:0] flt_data, out_data;
  logic [1:0] state;
`ifdef TRAP_CTRL_PEAK_EN
  logic signed [DW-1:0] peak_data;
  logic peak_valid;
`endif

  trap_filter_ctrl_if #(.KL_W(6), .M_W(8)) cfg_bus ();

  trap_filter_ctrl dut (
    .clk(clk), .reset(reset), .cfg(cfg_bus), .start(start), .stop(stop),
    .flt_clear(flt_clear), .flt_k(flt_k), .flt_l(flt_l), .flt_m(flt_m),
    .flt_data(flt_data), .out_data(out_data), .out_valid(out_valid),
`ifdef TRAP_CTRL_PEAK_EN
    .peak_data(peak_data), .peak_valid(peak_valid),
`endif
    .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_k = 8, exp_l = 12, exp_m = 16;

  typedef struct {
    int k; int l; int m; bit err;
  } cfg_vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic offer(input int k, input int l, input int m);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_k = k[5:0];
    cfg_bus.cfg_l = l[5:0];
    cfg_bus.cfg_m = m[7:0];
  endtask

  // Called one sample after the edge that launched FLUSH; measures phase lengths.
  task automatic wait_valid(input string tag, input int kl);
    int n = 1, fl = 0, se = 0, clr = 0;
    while (!out_valid && n < 400) begin
      if (state == 2'd1) fl++;
      if (state == 2'd2) se++;
      if (flt_clear) clr++;
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 2 * kl + PIPE_LAT + 3);
    chk({tag, "_flush_len"}, fl, kl + 1);
    chk({tag, "_settle_len"}, se, kl + PIPE_LAT);
    chk({tag, "_clear_len"}, clr, kl + 1);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(tag, exp_k + exp_l);
  endtask

  // Random data in RUN; returns max of samples seen with out_valid high.
  task automatic run_data(input string tag, input int cycles, output int peak);
    int prev;
    peak = -32768;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid && $signed(out_data) > peak) peak = $signed(out_data);
      prev = $signed(16'($urandom));
      flt_data = prev[DW-1:0];
      step();
      chk({tag, "_out_data"}, $signed(out_data), prev);
      chk({tag, "_out_valid"}, int'(out_valid), 1);
    end
    if (out_valid && $signed(out_data) > peak) peak = $signed(out_data);
  endtask

  cfg_vec_t tbl[$];

  initial begin
    int pk, keep;
    reset = 1'b1; start = 1'b0; stop = 1'b0; flt_data = '0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_k = '0; cfg_bus.cfg_l = '0; cfg_bus.cfg_m = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_k", flt_k, 8);
    chk("rst_l", flt_l, 12);
    chk("rst_m", flt_m, 16);
    chk("rst_clear", flt_clear, 1);
    chk("rst_ready", cfg_bus.cfg_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_state", state, 0);
    chk("rst_err", cfg_bus.cfg_err, 0);
    chk("rst_busy", busy, 0);
`ifdef TRAP_CTRL_PEAK_EN
    chk("rst_peak_valid", peak_valid, 0);
`endif

    tbl.push_back('{0, 5, 3, 1'b1});
    tbl.push_back('{10, 5, 3, 1'b1});
    tbl.push_back('{30, 30, 3, 1'b1});
    tbl.push_back('{63, 63, 3, 1'b1});
    tbl.push_back('{24, 25, 7, 1'b1});
    tbl.push_back('{24, 24, 7, 1'b0});
    tbl.push_back('{1, 1, 200, 1'b0});
    tbl.push_back('{8, 12, 16, 1'b0});
    foreach (tbl[i]) begin
      offer(tbl[i].k, tbl[i].l, tbl[i].m);
      step();
      cfg_bus.cfg_valid = 1'b0;
      if (!tbl[i].err) begin exp_k = tbl[i].k; exp_l = tbl[i].l; exp_m = tbl[i].m; end
      chk($sformatf("tbl%0d_err", i), cfg_bus.cfg_err, tbl[i].err);
      chk($sformatf("tbl%0d_k", i), flt_k, exp_k);
      chk($sformatf("tbl%0d_l", i), flt_l, exp_l);
      chk($sformatf("tbl%0d_m", i), flt_m, exp_m);
      chk($sformatf("tbl%0d_state", i), state, 0);
      step();
      chk($sformatf("tbl%0d_err_pulse", i), cfg_bus.cfg_err, 0);
    end

    // Config and start together in IDLE: config wins
    offer(8, 12, 16);
    start = 1'b1;
    step();
    start = 1'b0; cfg_bus.cfg_valid = 1'b0;
    chk("cfg_start_state", state, 0);

    do_start("dflt");
    run_data("dflt", 8, pk);

    // Reconfigure while running
    offer(4, 10, 32);
    step();
    cfg_bus.cfg_valid = 1'b0;
    exp_k = 4; exp_l = 10; exp_m = 32;
    chk("rcfg_k", flt_k, 4);
    chk("rcfg_l", flt_l, 10);
    chk("rcfg_m", flt_m, 32);
    chk("rcfg_state", state, 1);
    chk("rcfg_valid_drop", out_valid, 0);
    chk("rcfg_ready", cfg_bus.cfg_ready, 0);
    wait_valid("rcfg", 14);
    run_data("rcfg", 5, pk);

    // Invalid config in RUN leaves state alone
    offer(10, 5, 3);
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("run_bad_err", cfg_bus.cfg_err, 1);
    chk("run_bad_state", state, 3);
    chk("run_bad_k", flt_k, 4);

    // stop in RUN: out_data holds
    keep = $signed(out_data);
    flt_data = 16'sd1234;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_run_state", state, 0);
    chk("stop_run_hold", $signed(out_data), keep);
    chk("stop_run_valid", out_valid, 0);
    chk("stop_run_clear", flt_clear, 1);

    // stop mid-SETTLE with a config offered
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("mid_settle_state", state, 2);
    chk("mid_settle_busy", busy, 1);
    stop = 1'b1;
    offer(5, 5, 9);
    step();
    stop = 1'b0; cfg_bus.cfg_valid = 1'b0;
    chk("stop_settle_state", state, 0);
    chk("stop_settle_clear", flt_clear, 1);
    chk("stop_settle_k", flt_k, 4);
    chk("stop_settle_m", flt_m, 32);
    chk("stop_settle_err", cfg_bus.cfg_err, 0);
    step();
    chk("stop_settle_err2", cfg_bus.cfg_err, 0);

`ifdef TRAP_CTRL_PEAK_EN
    flt_data = '0;
    do_start("peak");
    foreach (tbl[i]) ; // no-op keeps loop style uniform
    begin
      int seq[4] = '{5, -3, 120, 7};
      for (int i = 0; i < 4; i++) begin
        flt_data = seq[i][DW-1:0];
        step();
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("peak_valid", peak_valid, 1);
    chk("peak_data", $signed(peak_data), 120);
    step();
    chk("peak_pulse", peak_valid, 0);
`endif

    // Randomized configurations checked against arithmetic latency and a data model
    for (int r = 0; r < 6; r++) begin
      int k, l, m;
      k = $urandom_range(1, 12);
      l = $urandom_range(k, 24);
      m = $urandom_range(0, 255);
      offer(k, l, m);
      step();
      cfg_bus.cfg_valid = 1'b0;
      exp_k = k; exp_l = l; exp_m = m;
      chk($sformatf("rnd%0d_k", r), flt_k, k);
      chk($sformatf("rnd%0d_m", r), flt_m, m);
      flt_data = '0;
      do_start($sformatf("rnd%0d", r));
      run_data($sformatf("rnd%0d", r), 12, pk);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk($sformatf("rnd%0d_stop", r), state, 0);
`ifdef TRAP_CTRL_PEAK_EN
      chk($sformatf("rnd%0d_peak_valid", r), peak_valid, 1);
      chk($sformatf("rnd%0d_peak", r), $signed(peak_data), pk);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
